// File: rtl/onchip_arb_pkg.sv
// Shared definitions for the on-chip RAM arbiter: master indices, owner states and
// default bus widths.
package onchip_arb_pkg;

  localparam int unsigned M_CPU    = 0;
  localparam int unsigned M_SERDES = 1;

  localparam int unsigned ADDR_W_DEFAULT = 10;
  localparam int unsigned DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The current owner may keep the bus for up to
// MAX_BURST consecutive grants while the other requester waits.
module rr_arb2
  import onchip_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output owner_e     owner
);

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  owner_e     state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       owner_keeps;

  assign owner = state_q;

  always_comb begin
    grant       = 2'b00;
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    owner_keeps = (state_q != IDLE) && (cnt_q < MaxBurst);

    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (owner_keeps) grant = (state_q == OWN1) ? 2'b10 : 2'b01;
        else             grant = last_q ? 2'b01 : 2'b10;
      end
      default: grant = 2'b00;
    endcase

    if (grant[0]) begin
      state_d = OWN0;
      last_d  = 1'b0;
      if (state_q != OWN0)     cnt_d = 4'd1;
      else if (cnt_q < MaxBurst) cnt_d = cnt_q + 4'd1;
    end else if (grant[1]) begin
      state_d = OWN1;
      last_d  = 1'b1;
      if (state_q != OWN1)     cnt_d = 4'd1;
      else if (cnt_q < MaxBurst) cnt_d = cnt_q + 4'd1;
    end else begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end
  end

  // last_q resets to master 1 so that master 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between the NIOS data master (0) and the SERDES
// engine (1); one access per clock, read data steered back via a one-cycle tag.
module onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W    = DATA_W_DEFAULT,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic       active_q;
  logic [1:0] req;
  logic [1:0] grant;
  owner_e     owner;
  logic       granted;
  logic       win_read;
  logic       win_write;
  logic       rd_pend_q;
  logic       rd_owner_q;

  // Holds off all requests for the first cycle after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) active_q <= 1'b0;
    else          active_q <= 1'b1;
  end

  assign req = {m1_read | m1_write, m0_read | m0_write} & {2{active_q}};

  rr_arb2 #(
    .MAX_BURST(MAX_BURST)
  ) u_arb (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (req),
    .grant  (grant),
    .owner  (owner)
  );

  assign granted = |grant;

  always_comb begin
    if (grant[M_SERDES]) begin
      mem_address    = m1_address;
      mem_writedata  = m1_writedata;
      mem_byteenable = m1_byteenable;
      win_read       = m1_read;
      win_write      = m1_write;
    end else begin
      mem_address    = m0_address;
      mem_writedata  = m0_writedata;
      mem_byteenable = m0_byteenable;
      win_read       = m0_read;
      win_write      = m0_write;
    end
  end

  assign mem_chipselect = granted;
  assign mem_write      = granted & win_write;
  assign mem_clken      = active_q;

  assign m0_waitrequest = ~grant[M_CPU];
  assign m1_waitrequest = ~grant[M_SERDES];

  // A read with write also asserted is serviced as a write, so it returns no data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q  <= granted & win_read & ~win_write;
      rd_owner_q <= grant[M_SERDES];
    end
  end

  assign m0_readdatavalid = rd_pend_q & ~rd_owner_q;
  assign m1_readdatavalid = rd_pend_q & rd_owner_q;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  proto_err_a : assert property (@(posedge clk) disable iff (!reset_n)
      !(m0_read && m0_write) && !(m1_read && m1_write))
    else $warning("master asserted read and write together; serviced as a write");

  owner_track_a : assert property (@(posedge clk) disable iff (!reset_n)
      (grant[M_CPU] |=> owner == OWN0) and (grant[M_SERDES] |=> owner == OWN1) and
      (!granted |=> owner == IDLE));

endmodule
